pulpemu_stdout_drain: RTL

PULPEMU_STDOUT_DRAIN -- requirements
Module: pulpemu_stdout_drain

---
 rtl/pulpemu_stdout_drain.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pulpemu_stdout_drain.sv
// Drains the four per-core stdout BRAM regions as a byte stream on a valid/ready
// interface, then pulses stdout_flushed_o so the upstream write counters can clear.
module pulpemu_stdout_drain #(
    parameter  int unsigned STDOUT_BUFFER_DIM = 65536,
    localparam int unsigned REGION_BYTES      = STDOUT_BUFFER_DIM / 4,
    localparam int unsigned WA                = $clog2(REGION_BYTES)
) (
    input  logic          ref_clk_i,
    input  logic          rst_ni,
    input  logic          fetch_en_i,
    input  logic          stdout_wait_i,
    input  logic          flush_req_i,
    input  logic [63:0]   wr_count_i,
    output logic          bram_en_o,
    output logic [WA-1:0] bram_addr_o,
    input  logic [31:0]   bram_rdata_i,
    output logic          out_valid_o,
    output logic [7:0]    out_data_o,
    output logic [1:0]    out_core_o,
    input  logic          out_ready_i,
    output logic          stdout_flushed_o,
    output logic          busy_o
);

    localparam int unsigned CW     = WA + 1;
    localparam int unsigned NCORES = 4;

    typedef enum logic [2:0] {IDLE, SCAN, READ, WAIT, SEND, DONE, HOLD} state_e;

    state_e        state_q, state_d;
    logic [2:0]    core_q, core_d;
    logic [WA-1:0] idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic [CW-1:0] cnt_q [NCORES];
    logic [CW-1:0] cnt_d [NCORES];
    logic          pend_q, pend_d;
    logic          hold_q, hold_d;
    logic          found;
    logic [2:0]    sel;
    logic [CW-1:0] next_pos;

    // Counts above the region size cannot be backed by BRAM, so saturate them.
    function automatic logic [CW-1:0] clamp(input logic [15:0] c);
        if (32'(c) > REGION_BYTES) return CW'(REGION_BYTES);
        return CW'(c);
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] l);
        logic [7:0] b;
        case (l)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        core_d   = core_q;
        idx_d    = idx_q;
        word_d   = word_q;
        pend_d   = pend_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        found    = 1'b0;
        sel      = '0;
        next_pos = CW'(idx_q) + CW'(1);

        for (int unsigned c = 0; c < NCORES; c++) begin
            if (!found && 3'(c) >= core_q && cnt_q[c] != '0) begin
                found = 1'b1;
                sel   = 3'(c);
            end
        end

        if (flush_req_i && state_q != IDLE) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (fetch_en_i && (stdout_wait_i || flush_req_i || pend_q)) begin
                    state_d = SCAN;
                    pend_d  = 1'b0;
                    core_d  = '0;
                    idx_d   = '0;
                    for (int unsigned c = 0; c < NCORES; c++) begin
                        cnt_d[c] = clamp(wr_count_i[16*c +: 16]);
                    end
                end
            end
            SCAN: begin
                if (found) begin
                    core_d  = sel;
                    state_d = READ;
                end else begin
                    state_d = DONE;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                word_d  = bram_rdata_i;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready_i) begin
                    idx_d = idx_q + WA'(1);
                    if (next_pos == cnt_q[core_q[1:0]]) begin
                        state_d = SCAN;
                        core_d  = core_q + 3'd1;
                        idx_d   = '0;
                    end else if (idx_d[1:0] == 2'd0) begin
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                hold_d  = 1'b0;
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q) begin
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!fetch_en_i) begin
            state_d = IDLE;
            pend_d  = 1'b0;
            hold_d  = 1'b0;
        end
    end

    // State register; outputs are registered from the next state so they align with it
    always_ff @(posedge ref_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            core_q           <= '0;
            idx_q            <= '0;
            word_q           <= '0;
            pend_q           <= 1'b0;
            hold_q           <= 1'b0;
            for (int unsigned c = 0; c < NCORES; c++) cnt_q[c] <= '0;
            bram_en_o        <= 1'b0;
            bram_addr_o      <= '0;
            out_valid_o      <= 1'b0;
            out_data_o       <= '0;
            out_core_o       <= '0;
            stdout_flushed_o <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            for (int unsigned c = 0; c < NCORES; c++) cnt_q[c] <= cnt_d[c];
            bram_en_o <= (state_d == READ);
            if (state_d == READ) bram_addr_o <= {core_d[1:0], idx_d[WA-1:2]};
            out_valid_o <= (state_d == SEND);
            if (state_d == SEND) begin
                out_data_o <= lane(word_d, idx_d[1:0]);
                out_core_o <= core_d[1:0];
            end
            stdout_flushed_o <= (state_d == DONE);
            busy_o           <= (state_d != IDLE);
        end
    end

endmodule
